cache_mem_arbiter: RTL

- Sits between the I-cache and D-cache miss logic and the single shared main memory (multi-cycle, pipelined memory4c).
- Grants memory to one requester at a time and issues the 8 word reads of a block fill.
- Counts returning valid words and steers each word to the granted cache with data-array and tag-array write strobes.
- Forwards D-cache write-through stores as single-cycle memory writes.

---
 rtl/cache_pkg.sv | 18 +
 rtl/cache_mem_arbiter_fill_counter.sv | 32 +++
 rtl/cache_mem_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the cache/memory arbiter slice.
//   arb_state_t  - arbiter FSM encoding (IDLE / I_FILL / D_FILL)
//   BLOCK_WORDS  - 16-bit words per cache block (block = 16 bytes)
//   BLOCK_MASK   - clears the byte offset within a block
//   DATA_W       - memory / cache word width
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        I_FILL = 2'b01,
        D_FILL = 2'b10
    } arb_state_t;

    localparam int          BLOCK_WORDS = 8;
    localparam int          DATA_W      = 16;
    localparam logic [15:0] BLOCK_MASK  = 16'hFFF0;

endpackage

// File: rtl/cache_mem_arbiter_fill_counter.sv
// fill_counter: small up-counter used for the issue and return sides of a
// block fill.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : advance by one; holds once LIMIT is reached
//   cnt      : current count
//   done     : cnt has reached LIMIT
module fill_counter #(
    parameter int CNT_W = 4,
    parameter int LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    assign done = (cnt == CNT_W'(LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !done) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one pipelined main memory between the I-cache
// and D-cache miss handlers and forwards D-cache write-through stores.
//   clk, rst                        : clock, asynchronous active-high reset
//   i_miss / i_miss_addr            : I-cache miss request and byte address
//   i_busy                          : I-cache fill in progress
//   i_write_data_array / _tag_array : I-cache fill strobes
//   d_miss / d_miss_addr            : D-cache miss request and byte address
//   d_busy                          : D-cache fill in progress
//   d_write_data_array / _tag_array : D-cache fill strobes
//   d_wr_req/_addr/_data, d_wr_ack  : write-through store handshake
//   fill_addr / fill_data           : returning word and its byte address
//   mem_enable/_wr/_addr/_data_in   : memory request
//   mem_data_out / mem_data_valid   : memory read return
module cache_mem_arbiter #(
    parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
    parameter int MEM_LATENCY = 4,
    parameter int ADDR_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_miss,
    input  logic [ADDR_W-1:0]            i_miss_addr,
    output logic                         i_busy,
    output logic                         i_write_data_array,
    output logic                         i_write_tag_array,
    input  logic                         d_miss,
    input  logic [ADDR_W-1:0]            d_miss_addr,
    output logic                         d_busy,
    output logic                         d_write_data_array,
    output logic                         d_write_tag_array,
    input  logic                         d_wr_req,
    input  logic [ADDR_W-1:0]            d_wr_addr,
    input  logic [cache_pkg::DATA_W-1:0] d_wr_data,
    output logic                         d_wr_ack,
    output logic [ADDR_W-1:0]            fill_addr,
    output logic [cache_pkg::DATA_W-1:0] fill_data,
    output logic                         mem_enable,
    output logic                         mem_wr,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [cache_pkg::DATA_W-1:0] mem_data_in,
    input  logic [cache_pkg::DATA_W-1:0] mem_data_out,
    input  logic                         mem_data_valid
);

    import cache_pkg::arb_state_t;
    import cache_pkg::IDLE;
    import cache_pkg::I_FILL;
    import cache_pkg::D_FILL;
    import cache_pkg::BLOCK_MASK;

    localparam int CNT_W = 4;

    // The FSM counts returned valids rather than cycles, so memory latency
    // does not affect the logic; it is only sanity-checked here.
    if (BLOCK_WORDS < 1 || BLOCK_WORDS > 15 || MEM_LATENCY < 1 || ADDR_W != 16) begin : g_param_check
        $error("cache_mem_arbiter: unsupported parameter combination");
    end

    arb_state_t        state_q, state_nxt;
    logic [ADDR_W-1:0] base_q, base_nxt;

    logic [CNT_W-1:0]  issue_cnt, ret_cnt;
    logic              issue_done, ret_done;
    logic              in_fill, issue_inc, ret_inc, last_ret, cnt_clr;

    assign in_fill   = (state_q == I_FILL) || (state_q == D_FILL);
    assign issue_inc = in_fill && !issue_done;
    assign ret_inc   = in_fill && mem_data_valid && !ret_done;
    assign last_ret  = ret_inc && (ret_cnt == CNT_W'(BLOCK_WORDS - 1));
    // Counters sit at zero while idle and are cleared on the tag-write
    // cycle so the next grant always starts from word 0.
    assign cnt_clr   = (state_q == IDLE) || last_ret;

    fill_counter #(.CNT_W(CNT_W), .LIMIT(BLOCK_WORDS)) u_issue_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (issue_inc),
        .cnt  (issue_cnt),
        .done (issue_done)
    );

    fill_counter #(.CNT_W(CNT_W), .LIMIT(BLOCK_WORDS)) u_ret_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (ret_inc),
        .cnt  (ret_cnt),
        .done (ret_done)
    );

    // State and block base register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_nxt;
            base_q  <= base_nxt;
        end
    end

    // Next state: a pending store always wins in IDLE, then D miss, then I miss.
    always_comb begin
        state_nxt = state_q;
        base_nxt  = base_q;
        case (state_q)
            IDLE: begin
                if (d_wr_req) begin
                    state_nxt = IDLE;
                end else if (d_miss) begin
                    state_nxt = D_FILL;
                    base_nxt  = d_miss_addr & BLOCK_MASK;
                end else if (i_miss) begin
                    state_nxt = I_FILL;
                    base_nxt  = i_miss_addr & BLOCK_MASK;
                end
            end
            I_FILL, D_FILL: begin
                if (last_ret) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: combinational from state and counters, forced to 0 while reset
    // is held so an abandoned fill cannot emit any strobe.
    always_comb begin
        mem_enable         = 1'b0;
        mem_wr             = 1'b0;
        mem_addr           = '0;
        mem_data_in        = '0;
        d_wr_ack           = 1'b0;
        fill_addr          = '0;
        fill_data          = '0;
        i_write_data_array = 1'b0;
        i_write_tag_array  = 1'b0;
        d_write_data_array = 1'b0;
        d_write_tag_array  = 1'b0;
        i_busy             = 1'b0;
        d_busy             = 1'b0;
        if (!rst) begin
            i_busy = (state_q == I_FILL);
            d_busy = (state_q == D_FILL);
            case (state_q)
                IDLE: begin
                    if (d_wr_req) begin
                        mem_enable  = 1'b1;
                        mem_wr      = 1'b1;
                        mem_addr    = d_wr_addr;
                        mem_data_in = d_wr_data;
                        d_wr_ack    = 1'b1;
                    end
                end
                I_FILL, D_FILL: begin
                    if (issue_inc) begin
                        mem_enable = 1'b1;
                        // base is block-aligned, so the word offset never carries.
                        mem_addr   = base_q + ADDR_W'({issue_cnt, 1'b0});
                    end
                    if (ret_inc) begin
                        fill_data = mem_data_out;
                        fill_addr = base_q + ADDR_W'({ret_cnt, 1'b0});
                        if (state_q == I_FILL) begin
                            i_write_data_array = 1'b1;
                            i_write_tag_array  = last_ret;
                        end else begin
                            d_write_data_array = 1'b1;
                            d_write_tag_array  = last_ret;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
